// File: rtl/matinv_arbiter.sv
// Two-requester round-robin front end for a shared 2x2 matrix-inverse datapath.
// Optional MATINV_ERR_STATS_EN adds a saturating err_count output.
module matinv_arbiter #(
   parameter int LATENCY = 3,
   parameter int W       = 16
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           req0_valid,
   output logic           req0_ready,
   input  logic [4*W-1:0] req0_mat,
   input  logic           req1_valid,
   output logic           req1_ready,
   input  logic [4*W-1:0] req1_mat,
   output logic [4*W-1:0] dp_mat,
   input  logic [4*W-1:0] dp_res,
   input  logic           dp_error,
   output logic           resp_valid,
   input  logic           resp_ready,
   output logic [4*W-1:0] resp_mat,
   output logic           resp_error,
   output logic           resp_id,
   output logic           busy
`ifdef MATINV_ERR_STATS_EN
   ,
   output logic [7:0]     err_count
`endif
);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t         state;
   logic [3:0]     cnt;
   logic [4*W-1:0] op_reg;
   logic           last_grant;
   logic           grant_id;
   logic           accept;

   // With both valid the requester not granted last wins; otherwise whoever is valid.
   always_comb begin
      grant_id = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
   end

   assign req0_ready = (state == IDLE) & req0_valid & ~grant_id;
   assign req1_ready = (state == IDLE) & req1_valid &  grant_id;
   assign accept     = req0_ready | req1_ready;
   assign dp_mat     = op_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= 4'd0;
         op_reg     <= '0;
         resp_mat   <= '0;
         resp_error <= 1'b0;
         resp_id    <= 1'b0;
         last_grant <= 1'b1;
         resp_valid <= 1'b0;
         busy       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  op_reg     <= grant_id ? req1_mat : req0_mat;
                  resp_id    <= grant_id;
                  last_grant <= grant_id;
                  cnt        <= 4'(LATENCY);
                  busy       <= 1'b1;
                  state      <= WAIT;
               end
            end
            WAIT: begin
               // Capture on the edge the counter hits zero: LATENCY edges after load.
               if (cnt == 4'd1) begin
                  resp_mat   <= dp_res;
                  resp_error <= dp_error;
                  cnt        <= 4'd0;
                  resp_valid <= 1'b1;
                  state      <= RESP;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  busy       <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: begin
               resp_valid <= 1'b0;
               busy       <= 1'b0;
               state      <= IDLE;
            end
         endcase
      end
   end

`ifdef MATINV_ERR_STATS_EN
   always_ff @(posedge clk) begin
      if (reset)
         err_count <= 8'd0;
      else if (resp_valid & resp_ready & resp_error & (err_count != 8'hFF))
         err_count <= err_count + 8'd1;
   end
`endif

endmodule

// File: tb/tb_matinv_arbiter.sv
// Directed bench for matinv_arbiter: vector table of arbitrated transactions plus
// hand sequences for reset, stall, abort and ignored-pulse cases.
module tb_matinv_arbiter;
   localparam int LAT = 3;
   localparam int W   = 16;

   logic           clk = 1'b0;
   logic           reset;
   logic           req0_valid, req1_valid, req0_ready, req1_ready;
   logic [4*W-1:0] req0_mat, req1_mat, dp_mat, dp_res;
   logic           dp_error;
   logic           resp_valid, resp_ready, resp_error, resp_id, busy;
   logic [4*W-1:0] resp_mat;
`ifdef MATINV_ERR_STATS_EN
   logic [7:0]     err_count;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   matinv_arbiter #(.LATENCY(LAT), .W(W)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_mat(req0_mat),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_mat(req1_mat),
      .dp_mat(dp_mat), .dp_res(dp_res), .dp_error(dp_error),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_mat(resp_mat),
      .resp_error(resp_error), .resp_id(resp_id), .busy(busy)
`ifdef MATINV_ERR_STATS_EN
      , .err_count(err_count)
`endif
   );

   // Datapath stand-in: adjugate {d,-b,-c,a}, error when the determinant is zero.
   logic signed [W-1:0]  ma, mb, mc, md;
   logic signed [31:0]   det;
   assign {ma, mb, mc, md} = dp_mat;
   assign det      = 32'(ma) * 32'(md) - 32'(mb) * 32'(mc);
   assign dp_res   = {md, -mb, -mc, ma};
   assign dp_error = (det == 32'sd0);

   localparam logic [63:0] ID = 64'h4000_0000_0000_4000;

   typedef struct {
      logic        v0, v1;
      logic [63:0] m0, m1;
      logic        exp_id;
      logic [63:0] exp_mat;
      logic        exp_err;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // Waits for resp_valid; cyc counts cycles after the acceptance cycle.
   task automatic wait_resp(input string name, output int cyc);
      cyc = 1;
      while (!resp_valid && cyc < 40) begin
         chk({name, "_wait_rdy"}, {req0_ready, req1_ready}, 2'b00);
         tick();
         cyc++;
      end
      chk({name, "_latency"}, 64'(cyc), 64'(LAT + 1));
   endtask

   task automatic run_vec(input string name, input vec_t v);
      int cyc;
      req0_valid = v.v0; req1_valid = v.v1; req0_mat = v.m0; req1_mat = v.m1;
      #1;
      chk({name, "_grant"}, {req0_ready, req1_ready}, v.exp_id ? 2'b01 : 2'b10);
      tick();
      req0_valid = 1'b0; req1_valid = 1'b0;
      chk({name, "_busy"}, busy, 1'b1);
      chk({name, "_dp_mat"}, dp_mat, v.exp_id ? v.m1 : v.m0);
      wait_resp(name, cyc);
      chk({name, "_resp_mat"}, resp_mat, v.exp_mat);
      chk({name, "_resp_id"}, resp_id, v.exp_id);
      chk({name, "_resp_err"}, resp_error, v.exp_err);
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      chk({name, "_idle"}, {resp_valid, busy}, 2'b00);
   endtask

   vec_t vecs[8];

   initial begin
      int cyc;
      vecs[0] = '{1, 1, ID, 64'h2000_0000_0000_2000, 0, ID, 0};
      vecs[1] = '{1, 1, ID, 64'h2000_0000_0000_2000, 1, 64'h2000_0000_0000_2000, 0};
      vecs[2] = '{1, 1, 64'h4000_0000_0000_C000, ID, 0, 64'hC000_0000_0000_4000, 0};
      vecs[3] = '{0, 1, ID, 64'h4000_1000_0000_4000, 1, 64'h4000_F000_0000_4000, 0};
      vecs[4] = '{0, 1, ID, 64'h1000_0000_2000_1000, 1, 64'h1000_0000_E000_1000, 0};
      vecs[5] = '{1, 1, 64'h4000_4000_4000_4000, ID, 0, 64'h4000_C000_C000_4000, 1};
      vecs[6] = '{1, 0, 64'h0000_4000_C000_0000, ID, 0, 64'h0000_C000_4000_0000, 0};
      vecs[7] = '{1, 1, 64'h0000_4000_C000_0000, ID, 1, ID, 0};

      reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
      req0_mat = '0; req1_mat = '0; resp_ready = 1'b0;
      tick(); tick();
      chk("rst_flags", {resp_valid, busy, req0_ready, req1_ready}, 4'b0000);
      chk("rst_dp_mat", dp_mat, 64'h0);
      chk("rst_resp", {resp_mat, resp_error, resp_id}, 66'h0);
      reset = 1'b0;
      tick();
      chk("post_rst_flags", {resp_valid, busy, req0_ready, req1_ready}, 4'b0000);

      foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i]);

      // Stall: consumer holds off 10 cycles while req0 keeps a new matrix pending.
      req0_valid = 1'b1; req0_mat = ID; #1;
      chk("stall_grant", {req0_ready, req1_ready}, 2'b10);
      tick();
      req0_mat = 64'h1234_5678_9ABC_DEF0;
      wait_resp("stall", cyc);
      for (int k = 0; k < 10; k++) begin
         chk("stall_valid", resp_valid, 1'b1);
         chk("stall_mat", resp_mat, ID);
         chk("stall_rdy", {req0_ready, req1_ready}, 2'b00);
         chk("stall_dp_mat", dp_mat, ID);
         tick();
      end
      resp_ready = 1'b1; #1;
      chk("consume_rdy", {req0_ready, req1_ready}, 2'b00);
      tick();
      resp_ready = 1'b0;
      chk("after_consume_rdy", {req0_ready, req1_ready, resp_valid}, 3'b100);
      req0_valid = 1'b0;
      tick();

      // Reset during WAIT discards the operation.
      req0_valid = 1'b1; req0_mat = 64'h4000_4000_4000_4000; #1;
      chk("abort_grant", req0_ready, 1'b1);
      tick();
      req0_valid = 1'b0; reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("abort_busy", {busy, resp_valid}, 2'b00);
      for (int k = 0; k < LAT + 3; k++) begin
         chk("abort_no_resp", resp_valid, 1'b0);
         tick();
      end
      run_vec("after_abort", '{0, 1, ID, 64'h2000_0000_0000_2000, 1,
                               64'h2000_0000_0000_2000, 0});

      // req1 pulse during WAIT is never accepted.
      req0_valid = 1'b1; req0_mat = ID; #1;
      chk("pulse_grant", req0_ready, 1'b1);
      tick();
      req0_valid = 1'b0; req1_valid = 1'b1; req1_mat = 64'h4000_4000_4000_4000; #1;
      chk("pulse_rdy1", req1_ready, 1'b0);
      tick();
      req1_valid = 1'b0;
      cyc = 2;
      while (!resp_valid && cyc < 40) begin tick(); cyc++; end
      chk("pulse_latency", 64'(cyc), 64'(LAT + 1));
      chk("pulse_resp_id", resp_id, 1'b0);
      resp_ready = 1'b1; tick(); resp_ready = 1'b0;
      for (int k = 0; k < LAT + 3; k++) begin
         chk("pulse_no_resp", {resp_valid, busy}, 2'b00);
         tick();
      end

`ifdef MATINV_ERR_STATS_EN
      reset = 1'b1; tick(); reset = 1'b0; tick();
      chk("errcnt_rst", err_count, 8'd0);
      for (int k = 0; k < 300; k++) begin
         run_vec("sing", '{1, 0, 64'h4000_4000_4000_4000, ID, 0,
                           64'h4000_C000_C000_4000, 1});
         if (k == 0) chk("errcnt_one", err_count, 8'd1);
      end
      chk("errcnt_sat", err_count, 8'd255);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
